// File: rtl/main_memory.sv
// main_memory: fixed-latency word-addressed backing store behind the L1 cache; MEM_INIT_EN selects the {addr, ~addr} power-up pattern.
module main_memory #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 20,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_ready,
    output logic              mem_busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written = '0;
    logic [DATA_W-1:0] init_word;
    logic              accept;
    logic              fire;

`ifdef MEM_INIT_EN
    assign init_word = DATA_W'({addr, ~addr});
`else
    assign init_word = '0;
`endif

    // The RESP cycle doubles as an idle slot so a held mem_req chains the next access without a gap.
    assign accept   = mem_req && (state == IDLE || state == RESP);
    assign fire     = state == BUSY && cnt == 4'd0;
    assign mem_busy = state != IDLE;

    // Handshake FSM, latency counter, request capture and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            addr         <= '0;
            rw           <= 1'b0;
            wdata        <= '0;
            mem_ready    <= 1'b0;
            mem_data_out <= '0;
        end else begin
            mem_ready <= fire;
            if (accept) begin
                addr  <= mem_addr;
                rw    <= mem_rw;
                wdata <= mem_data_in;
                cnt   <= LOAD;
                state <= BUSY;
            end else if (fire) begin
                state <= RESP;
            end else if (state == RESP) begin
                state <= IDLE;
            end else if (state == BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && !rw) mem_data_out <= written[addr] ? mem[addr] : init_word;
        end
    end

    // Array write at completion; words never written read back as their power-up pattern.
    always_ff @(posedge clk) begin
        if (fire && rw) begin
            mem[addr]     <= wdata;
            written[addr] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: scoreboard bench for main_memory at LATENCY=4 plus a LATENCY=1 instance.
module tb_main_memory;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, rw = 1'b0;
    logic [9:0]  addr = '0;
    logic [19:0] din = '0;
    logic [19:0] dout;
    logic        ready, busy;
    logic        req1 = 1'b0;
    logic [9:0]  addr1 = '0;
    logic [19:0] dout1;
    logic        ready1, busy1;

    int          checks = 0;
    int          errors = 0;
    logic [19:0] sb[$];
    logic [19:0] exp_mem [1024];
    logic [19:0] last_rd = '0;

`ifdef MEM_INIT_EN
    localparam bit INIT = 1'b1;
`else
    localparam bit INIT = 1'b0;
`endif

    main_memory #(.LATENCY(4)) dut (
        .clk(clk), .rst(rst), .mem_req(req), .mem_rw(rw), .mem_addr(addr),
        .mem_data_in(din), .mem_data_out(dout), .mem_ready(ready), .mem_busy(busy)
    );

    main_memory #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .mem_req(req1), .mem_rw(1'b0), .mem_addr(addr1),
        .mem_data_in(20'h0), .mem_data_out(dout1), .mem_ready(ready1), .mem_busy(busy1)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] init_val(input logic [9:0] a);
        return INIT ? {a, ~a} : 20'h0;
    endfunction

    // Drive a request, record its expected data_out in the model/scoreboard, and step past the acceptance edge.
    task automatic issue(input logic w, input logic [9:0] a, input logic [19:0] d);
        req = 1'b1; rw = w; addr = a; din = d;
        if (w) exp_mem[a] = d;
        else last_rd = exp_mem[a];
        sb.push_back(last_rd);
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string name, input int exp_lat, input bit chk_drop);
        int n = 0;
        logic [19:0] e;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready && n < 20);
        checks++;
        if (!ready || n != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d ready=%b, expected %0d", name, n, ready, exp_lat);
        end
        e = sb.size() > 0 ? sb.pop_front() : 20'hxxxxx;
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL %s data: got %h expected %h", name, dout, e);
        end
        if (chk_drop) begin
            @(posedge clk); #1;
            checks++;
            if (ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s pulse end: ready=%b busy=%b expected 0 0", name, ready, busy);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, busy, dout} !== 22'h0) begin
            errors++;
            $display("FAIL reset outputs: got %h expected 0", {ready, busy, dout});
        end
        checks++;
        if ({ready1, busy1, dout1} !== 22'h0) begin
            errors++;
            $display("FAIL reset outputs lat1: got %h expected 0", {ready1, busy1, dout1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_first_read;
        issue(1'b0, 10'h005, 20'h0);
        req = 1'b0;
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL first busy: busy=%b ready=%b expected 1 0", busy, ready);
        end
        wait_ready("first_read", 4, 1'b1);
    endtask

    task automatic test_write_read;
        issue(1'b1, 10'h3FF, 20'hABCDE);
        req = 1'b0;
        wait_ready("write_3ff", 4, 1'b1);
        issue(1'b0, 10'h3FF, 20'h0);
        req = 1'b0;
        wait_ready("read_3ff", 4, 1'b1);
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 10'h021, 20'h12345);
        wait_ready("chain_write", 4, 1'b0);
        issue(1'b0, 10'h041, 20'h0);
        req = 1'b0;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL chain accept: ready=%b busy=%b expected 0 1", ready, busy);
        end
        wait_ready("chain_read", 4, 1'b1);
        issue(1'b0, 10'h021, 20'h0);
        req = 1'b0;
        wait_ready("chain_verify", 4, 1'b1);
    endtask

    task automatic test_churn;
        bit extra = 1'b0;
        issue(1'b0, 10'h010, 20'h0);
        addr = 10'h020; rw = 1'b1; din = 20'hFFFFF;
        @(posedge clk); #1;
        req = 1'b0;
        wait_ready("churn", 3, 1'b1);
        repeat (8) begin
            @(posedge clk); #1;
            if (ready || busy) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL churn second txn: activity seen, expected none");
        end
        rw = 1'b0;
        issue(1'b0, 10'h020, 20'h0);
        req = 1'b0;
        wait_ready("churn_untouched", 4, 1'b1);
    endtask

    task automatic test_reset_mid_write;
        bit seen = 1'b0;
        req = 1'b1; rw = 1'b1; addr = 10'h100; din = 20'h0FFFF;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, dout} !== 22'h0) begin
            errors++;
            $display("FAIL mid reset async: got %h expected 0", {ready, busy, dout});
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ready, busy, dout} !== 22'h0) begin
            errors++;
            $display("FAIL mid reset held: got %h expected 0", {ready, busy, dout});
        end
        rst = 1'b0;
        last_rd = 20'h0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid reset ready: pulse seen, expected none");
        end
        issue(1'b0, 10'h100, 20'h0);
        req = 1'b0;
        wait_ready("after_reset_read", 4, 1'b1);
    endtask

    task automatic test_latency1;
        @(negedge clk);
        req1 = 1'b1; addr1 = 10'h007;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) addr1 = 10'(8 + i);
            else req1 = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (ready1 !== 1'b1 || dout1 !== init_val(10'(7 + i))) begin
                errors++;
                $display("FAIL lat1 ready %0d: ready=%b data=%h expected 1 %h", i, ready1, dout1, init_val(10'(7 + i)));
            end
            @(posedge clk); #1;
            checks++;
            if (ready1 !== 1'b0 || busy1 !== (i < 2)) begin
                errors++;
                $display("FAIL lat1 gap %0d: ready=%b busy=%b expected 0 %b", i, ready1, busy1, i < 2);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(10'(i));
        test_reset;
        test_first_read;
        test_write_read;
        test_back_to_back;
        test_churn;
        test_reset_mid_write;
        test_latency1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
